pu_policy_loader: RTL

Boot-time configuration sequencer for the protection units. On a `start` pulse it programs the policy register of each of `NUM_PU` protection units over a single AXI4-Lite master port, optionally reads each one back to verify it, and reports done or error. It sits on the config interconnect in place of the software or VIP config master, ahead of the protection units' config slave ports.

---
 rtl/pu_policy_loader.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/pu_policy_loader.sv
// pu_policy_loader: boot-time AXI4-Lite policy programmer for NUM_PU protection units; define PU_LOADER_VERIFY_EN for readback verify.
module pu_policy_loader #(
    parameter int unsigned NUM_PU        = 2,
    parameter logic [31:0] PU_BASE       = 32'h0000_0000,
    parameter logic [31:0] PU_STRIDE     = 32'h0001_0000,
    parameter logic [31:0] POLICY_OFFSET = 32'h40,
    parameter logic [31:0] VERIFY_MASK   = 32'hFFFF_FFFF
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   start,
    input  logic [NUM_PU*32-1:0]   policy_in,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [3:0]             err_index,
    output logic [1:0]             err_code,
    output logic [31:0]            m_axi_awaddr,
    output logic [2:0]             m_axi_awprot,
    output logic                   m_axi_awvalid,
    input  logic                   m_axi_awready,
    output logic [31:0]            m_axi_wdata,
    output logic [3:0]             m_axi_wstrb,
    output logic                   m_axi_wvalid,
    input  logic                   m_axi_wready,
    input  logic [1:0]             m_axi_bresp,
    input  logic                   m_axi_bvalid,
    output logic                   m_axi_bready,
    output logic [31:0]            m_axi_araddr,
    output logic [2:0]             m_axi_arprot,
    output logic                   m_axi_arvalid,
    input  logic                   m_axi_arready,
    input  logic [31:0]            m_axi_rdata,
    input  logic [1:0]             m_axi_rresp,
    input  logic                   m_axi_rvalid,
    output logic                   m_axi_rready
);
    typedef enum logic [2:0] {
        IDLE, WR, WB,
`ifdef PU_LOADER_VERIFY_EN
        RD, RR,
`endif
        DONE, ERR
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          idx_q, idx_d;
    logic [NUM_PU*32-1:0] shadow_q, shadow_d;
    logic [31:0]         addr_q, addr_d, wdata_q, wdata_d;
    logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic                busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic [3:0]          err_index_q, err_index_d;
    logic [1:0]          err_code_q, err_code_d;
    logic                advance, last;
    logic [3:0]          idx_nx;

    function automatic logic [31:0] pu_addr(input logic [3:0] i);
        return PU_BASE + 32'(i) * PU_STRIDE + POLICY_OFFSET;
    endfunction

    assign last   = idx_q == 4'(NUM_PU - 1);
    assign idx_nx = idx_q + 4'd1;

`ifdef PU_LOADER_VERIFY_EN
    logic arvalid_q, arvalid_d, rready_q, rready_d;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;
`else
    logic unused_ok;
    assign unused_ok     = ^{VERIFY_MASK, m_axi_arready, m_axi_rvalid, m_axi_rresp, m_axi_rdata};
    assign m_axi_arvalid = 1'b0;
    assign m_axi_rready  = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        err_index_d = err_index_q;
        err_code_d  = err_code_q;
`ifdef PU_LOADER_VERIFY_EN
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
`endif
        advance     = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                shadow_d    = policy_in;
                done_d      = 1'b0;
                error_d     = 1'b0;
                err_index_d = 4'd0;
                err_code_d  = 2'b00;
                idx_d       = 4'd0;
                addr_d      = pu_addr(4'd0);
                wdata_d     = policy_in[31:0];
                awvalid_d   = 1'b1;
                wvalid_d    = 1'b1;
                busy_d      = 1'b1;
                state_d     = WR;
            end
            // AW and W retire independently; move on only once both have gone
            WR: begin
                awvalid_d = awvalid_q & ~m_axi_awready;
                wvalid_d  = wvalid_q & ~m_axi_wready;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WB;
                end
            end
            WB: if (m_axi_bvalid) begin
                bready_d = 1'b0;
                if (m_axi_bresp != 2'b00) begin
                    err_code_d  = 2'b01;
                    err_index_d = idx_q;
                    state_d     = ERR;
                end
`ifdef PU_LOADER_VERIFY_EN
                else begin
                    arvalid_d = 1'b1;
                    state_d   = RD;
                end
`else
                else advance = 1'b1;
`endif
            end
`ifdef PU_LOADER_VERIFY_EN
            RD: if (m_axi_arready) begin
                arvalid_d = 1'b0;
                rready_d  = 1'b1;
                state_d   = RR;
            end
            RR: if (m_axi_rvalid) begin
                rready_d = 1'b0;
                if (m_axi_rresp != 2'b00) begin
                    err_code_d  = 2'b10;
                    err_index_d = idx_q;
                    state_d     = ERR;
                end else if (((m_axi_rdata ^ shadow_q[32*idx_q +: 32]) & VERIFY_MASK) != 32'd0) begin
                    err_code_d  = 2'b11;
                    err_index_d = idx_q;
                    state_d     = ERR;
                end else advance = 1'b1;
            end
`endif
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            ERR: begin
                error_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (advance) begin
            if (last) state_d = DONE;
            else begin
                idx_d     = idx_nx;
                addr_d    = pu_addr(idx_nx);
                wdata_d   = shadow_q[32*idx_nx +: 32];
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
                state_d   = WR;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            idx_q       <= 4'd0;
            shadow_q    <= '0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_index_q <= 4'd0;
            err_code_q  <= 2'b00;
`ifdef PU_LOADER_VERIFY_EN
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_index_q <= err_index_d;
            err_code_q  <= err_code_d;
`ifdef PU_LOADER_VERIFY_EN
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
`endif
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign err_index     = err_index_q;
    assign err_code      = err_code_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
endmodule
